// File: rtl/pipe_stage_buf.sv
// Generic pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer, flush-to-bubble, occupancy and saturating stall/bubble counters.
module pipe_stage_buf #(
  parameter int unsigned          PAYLOAD_W   = 64,
  parameter logic [PAYLOAD_W-1:0] NOP_PAYLOAD = '0,
  parameter bit                   SKID        = 1'b1,
  parameter int unsigned          CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [PAYLOAD_W-1:0] in_payload,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [PAYLOAD_W-1:0] out_payload,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     stall_cnt,
  output logic [CNT_W-1:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PAYLOAD_W-1:0] main_q, main_d;
  logic [PAYLOAD_W-1:0] skid_q, skid_d;
  logic                 in_ready_q;
  logic                 in_fire, out_fire;

  assign out_valid   = (state_q != ST_EMPTY);
  assign out_payload = main_q;
  // Skid mode registers in_ready off the next state; otherwise it is pass-through.
  assign in_ready    = SKID ? in_ready_q : (!out_valid || out_ready);
  assign in_fire     = in_valid & in_ready;
  assign out_fire    = out_valid & out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state_q)
      ST_FULL: occupancy = 2'd1;
      ST_SKID: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = ST_EMPTY;
      main_d  = NOP_PAYLOAD;
      skid_d  = NOP_PAYLOAD;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_fire) begin
            state_d = ST_FULL;
            main_d  = in_payload;
          end
        end
        ST_FULL: begin
          if (in_fire && out_fire) begin
            main_d = in_payload;
          end else if (in_fire) begin
            // Without a skid entry in_ready implies out_ready, so this is skid-only.
            if (SKID) begin
              state_d = ST_SKID;
              skid_d  = in_payload;
            end
          end else if (out_fire) begin
            state_d = ST_EMPTY;
            main_d  = NOP_PAYLOAD;
          end
        end
        ST_SKID: begin
          if (out_fire) begin
            state_d = ST_FULL;
            main_d  = skid_q;
            skid_d  = NOP_PAYLOAD;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_d  = NOP_PAYLOAD;
          skid_d  = NOP_PAYLOAD;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      main_q     <= NOP_PAYLOAD;
      skid_q     <= NOP_PAYLOAD;
      in_ready_q <= 1'b1;
      stall_cnt  <= '0;
      bubble_cnt <= '0;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= (state_d != ST_SKID);
      if (out_valid && !out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (!out_valid && out_ready && (bubble_cnt != '1))
        bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Scoreboard bench for pipe_stage_buf: skid instance (CNT_W=4) and a
// single-register instance, directed stimulus with hand-computed expectations.
module tb_pipe_stage_buf;

  localparam logic [7:0] NOP = 8'hEE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Instance A: skid buffer, 4-bit counters
  logic       a_rst = 1'b1, a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
  logic [7:0] a_in_payload = 8'h00;
  logic       a_in_ready, a_out_valid;
  logic [7:0] a_out_payload;
  logic [1:0] a_occ;
  logic [3:0] a_stall, a_bubble;

  // Instance B: single register, combinational in_ready
  logic        b_rst = 1'b1, b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
  logic [7:0]  b_in_payload = 8'h00;
  logic        b_in_ready, b_out_valid;
  logic [7:0]  b_out_payload;
  logic [1:0]  b_occ;
  logic [15:0] b_stall, b_bubble;

  pipe_stage_buf #(.PAYLOAD_W(8), .NOP_PAYLOAD(8'hEE), .SKID(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .rst(a_rst), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_payload(a_in_payload),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_payload(a_out_payload),
    .occupancy(a_occ), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
  );

  pipe_stage_buf #(.PAYLOAD_W(8), .NOP_PAYLOAD(8'hEE), .SKID(1'b0), .CNT_W(16)) dut_b (
    .clk(clk), .rst(b_rst), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_payload(b_in_payload),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_payload(b_out_payload),
    .occupancy(b_occ), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  // Monitor: pop/compare on output transfer, drop on flush/reset, push on accept.
  always @(negedge clk) begin
    logic [7:0] e;
    if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
      if (qa.size() == 0) check("a_extra_output", 32'(a_out_payload), 32'hFFFF_FFFF);
      else begin
        e = qa.pop_front();
        check("a_out_payload", 32'(a_out_payload), 32'(e));
      end
    end else if (a_out_valid === 1'b0) begin
      check("a_nop_when_idle", 32'(a_out_payload), 32'(NOP));
    end
    if (a_rst || a_flush) qa.delete();
    else if (a_in_valid && a_in_ready) qa.push_back(a_in_payload);

    if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
      if (qb.size() == 0) check("b_extra_output", 32'(b_out_payload), 32'hFFFF_FFFF);
      else begin
        e = qb.pop_front();
        check("b_out_payload", 32'(b_out_payload), 32'(e));
      end
    end
    if (b_rst || b_flush) qb.delete();
    else if (b_in_valid && b_in_ready) qb.push_back(b_in_payload);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_reset(input string tag);
    check({tag, "_valid"},  32'(a_out_valid),   32'd0);
    check({tag, "_payload"}, 32'(a_out_payload), 32'(NOP));
    check({tag, "_occ"},    32'(a_occ),         32'd0);
    check({tag, "_ready"},  32'(a_in_ready),    32'd1);
    check({tag, "_stall"},  32'(a_stall),       32'd0);
    check({tag, "_bubble"}, 32'(a_bubble),      32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] exp_ir;
    logic [7:0] b_next;

    // Reset then stream 0x1..0x5
    tick();
    a_rst = 1'b0;
    check_a_reset("a_reset");
    for (int i = 1; i <= 5; i++) begin
      a_in_valid = 1'b1; a_in_payload = 8'(i); a_out_ready = 1'b1;
      tick();
      check("a_stream_occ", 32'(a_occ), 32'd1);
      check("a_stream_payload", 32'(a_out_payload), 32'(i));
    end
    a_in_valid = 1'b0;
    tick();
    check("a_stream_drained_occ", 32'(a_occ), 32'd0);
    check("a_stream_stall", 32'(a_stall), 32'd0);
    check("a_stream_bubble", 32'(a_bubble), 32'd1);

    // Skid fill: hold 0xA, present 0xB with out_ready low
    a_out_ready = 1'b0; a_in_valid = 1'b1; a_in_payload = 8'h0A;
    tick();
    a_in_payload = 8'h0B;
    tick();
    check("a_skid_occ", 32'(a_occ), 32'd2);
    check("a_skid_in_ready", 32'(a_in_ready), 32'd0);
    check("a_skid_payload", 32'(a_out_payload), 32'h0A);
    check("a_skid_stall", 32'(a_stall), 32'd1);
    a_in_valid = 1'b0; a_in_payload = 8'h77;
    tick();
    check("a_skid_hold_payload", 32'(a_out_payload), 32'h0A);
    check("a_skid_hold_stall", 32'(a_stall), 32'd2);
    a_out_ready = 1'b1;
    tick();
    check("a_skid_drain_occ", 32'(a_occ), 32'd1);
    check("a_skid_drain_ready", 32'(a_in_ready), 32'd1);
    check("a_skid_drain_payload", 32'(a_out_payload), 32'h0B);
    tick();
    check("a_skid_empty_occ", 32'(a_occ), 32'd0);
    a_out_ready = 1'b0;

    // Flush in SKID state with in_valid=1 payload 0xC
    a_in_valid = 1'b1; a_in_payload = 8'h21;
    tick();
    a_in_payload = 8'h22;
    tick();
    check("a_preflush_occ", 32'(a_occ), 32'd2);
    a_flush = 1'b1; a_in_payload = 8'h0C;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("a_flush_valid", 32'(a_out_valid), 32'd0);
    check("a_flush_payload", 32'(a_out_payload), 32'(NOP));
    check("a_flush_occ", 32'(a_occ), 32'd0);
    check("a_flush_ready", 32'(a_in_ready), 32'd1);
    // Flush from FULL while an upstream transfer fires: it is dropped
    a_in_valid = 1'b1; a_in_payload = 8'h31;
    tick();
    a_flush = 1'b1; a_in_payload = 8'h0C;
    tick();
    a_flush = 1'b0; a_in_valid = 1'b0;
    check("a_flush_full_valid", 32'(a_out_valid), 32'd0);
    check("a_flush_full_occ", 32'(a_occ), 32'd0);

    // Stall counter saturation at 15
    a_in_valid = 1'b1; a_in_payload = 8'h41;
    tick();
    a_in_valid = 1'b0;
    repeat (20) tick();
    check("a_stall_saturated", 32'(a_stall), 32'd15);
    a_flush = 1'b1;
    tick();
    a_flush = 1'b0;
    check("a_stall_after_flush", 32'(a_stall), 32'd15);
    check("a_bubble_before_rst", 32'(a_bubble), 32'd1);
    a_rst = 1'b1;
    tick();
    a_rst = 1'b0;
    check("a_stall_after_rst", 32'(a_stall), 32'd0);

    // Reset mid-transfer while in SKID with flush asserted
    a_in_valid = 1'b1; a_in_payload = 8'h51;
    tick();
    a_in_payload = 8'h52;
    tick();
    check("a_pre_rst_occ", 32'(a_occ), 32'd2);
    a_rst = 1'b1; a_flush = 1'b1; a_out_ready = 1'b1; a_in_payload = 8'h53;
    tick();
    a_rst = 1'b0; a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b0;
    check_a_reset("a_midrst");

    // SKID=0 back-pressure: out_ready 1,0,1,0,... with continuous input
    b_rst = 1'b0;
    check("b_reset_ready", 32'(b_in_ready), 32'd1);
    check("b_reset_occ", 32'(b_occ), 32'd0);
    exp_ir = 8'b0101_0101;
    b_next = 8'h10;
    for (int c = 0; c < 8; c++) begin
      b_in_valid = 1'b1; b_in_payload = b_next; b_out_ready = (c % 2 == 0);
      #1;
      check("b_in_ready", 32'(b_in_ready), 32'(exp_ir[c]));
      if (exp_ir[c]) b_next = b_next + 8'd1;
      tick();
      check("b_occ_not_2", 32'(b_occ == 2'd2), 32'd0);
    end
    b_in_valid = 1'b0; b_out_ready = 1'b1;
    tick();
    tick();
    check("b_drained_occ", 32'(b_occ), 32'd0);
    check("b_accepted_count", 32'(b_next), 32'h14);
    check("b_stall", 32'(b_stall), 32'd4);
    check("b_bubble", 32'(b_bubble), 32'd2);

    tick();
    check("a_queue_empty", 32'(qa.size()), 32'd0);
    check("b_queue_empty", 32'(qb.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
Parametrised pipeline stage register replacing the hand-written per-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB) with one generic block.
- Carries an opaque payload bus of configurable width.
- Uses a valid/ready handshake instead of a global stall vector.
- Optional 2-entry skid buffer fully decouples ready timing between stages.
- Adds flush-to-bubble, occupancy reporting and saturating stall/bubble performance counters.
- Sits between any two adjacent core pipeline stages.

Parameters:
PAYLOAD_W, 64, payload width in bits (opcode, operands, addresses, exception bits concatenated by the instantiating stage)
NOP_PAYLOAD, 0, payload value driven whenever the stage holds a bubble
SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single register with combinational in_ready
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
flush  in  1  discard all held entries; stage becomes empty
in_valid  in  1  upstream payload valid
in_ready  out  1  stage can accept upstream payload this cycle
in_payload  in  PAYLOAD_W  upstream payload
out_valid  out  1  output payload valid
out_ready  in  1  downstream accepts output this cycle
out_payload  out  PAYLOAD_W  held payload; NOP_PAYLOAD when out_valid=0
occupancy  out  2  entries held (0, 1, 2)
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating
bubble_cnt  out  CNT_W  cycles with out_valid=0 and out_ready=1, saturating

Behaviour:
- Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset (rst=1 at posedge):
  - out_valid=0, out_payload=NOP_PAYLOAD, skid entry invalid and cleared to NOP_PAYLOAD.
  - occupancy=0, stall_cnt=0, bubble_cnt=0.
  - in_ready=1 in the cycle after reset.
  - Reset overrides flush and all handshakes, including mid-transfer.
- Priority: rst > flush > handshake.
- Flush:
  - Next state is EMPTY; out_payload=NOP_PAYLOAD; skid cleared.
  - A payload with in_fire in the flush cycle is dropped.
  - Counters are not cleared by flush.
- State machine, SKID=1:
  - EMPTY (occ 0):
    - in_fire -> FULL, main <= in_payload.
    - Otherwise stay.
  - FULL (occ 1):
    - in_fire & out_fire -> FULL, main <= in_payload.
    - in_fire & !out_fire -> SKID, skid <= in_payload.
    - !in_fire & out_fire -> EMPTY, main <= NOP_PAYLOAD.
    - Otherwise hold.
  - SKID (occ 2):
    - out_fire -> FULL, main <= skid, skid <= NOP_PAYLOAD.
    - Otherwise hold.
  - in_ready is a register output, equal to (next state != SKID). It is 0 only in SKID.
- SKID=0:
  - No SKID state.
  - in_ready = !out_valid | out_ready (combinational).
  - Transitions as EMPTY/FULL above; occupancy never exceeds 1.
- Timing:
  - Latency is 1 cycle: in_fire at edge N gives out_valid=1 with that payload after edge N.
  - Sustained throughput is 1 transfer per cycle when out_ready=1.
- Ordering: payloads leave in acceptance order; no loss or duplication except on flush or reset.
- Payload stability: out_payload is stable while out_valid=1 and out_ready=0.
- Counters:
  - Update every non-reset cycle, including flush cycles, based on pre-edge out_valid/out_ready.
  - Saturate at 2^CNT_W-1; no wrap.
- in_payload is ignored when in_fire=0.

Test Plan:
- Reset then stream: rst 1 cycle; in_valid=1 with payloads 0x1..0x5 on consecutive cycles, out_ready=1 -> out_payload 0x1..0x5 on cycles 1..5 after first accept; occupancy=1 throughout; stall_cnt=0.
- Skid fill (SKID=1): hold 0xA, out_ready=0, present 0xB -> occupancy=2, in_ready=0 next cycle, out_payload stays 0xA; out_ready=1 -> 0xA then 0xB; in_ready returns 1 after 0xA leaves.
- Flush in SKID state with simultaneous in_valid=1 payload 0xC -> next cycle out_valid=0, out_payload=NOP_PAYLOAD, occupancy=0, in_ready=1; 0xC never appears.
- Counter saturation (CNT_W=4): out_valid=1, out_ready=0 for 20 cycles -> stall_cnt reaches 15 and holds; flush leaves it at 15; rst clears it to 0.
- SKID=0 back-pressure: out_ready toggles 1,0,1,0 with continuous input 0x10.. -> in_ready follows out_ready when full; no payload dropped or duplicated; occupancy never 2.
- Reset mid-transfer: rst asserted while in SKID with flush=1 -> all outputs return to reset values next cycle; bubble_cnt=0.
